// File: rtl/niosii_usb_cpu_cpu_debug_mem_sequencer_if.sv
// Avalon-style word bus between the debug memory sequencer and OCI memory.
interface niosii_usb_cpu_cpu_debug_mem_sequencer_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] mem_address;
  logic              mem_read;
  logic              mem_write;
  logic [DATA_W-1:0] mem_writedata;
  logic [DATA_W-1:0] mem_readdata;
  logic              mem_waitrequest;

  modport master (
    output mem_address, mem_read, mem_write, mem_writedata,
    input  mem_readdata, mem_waitrequest
  );

  modport slave (
    input  mem_address, mem_read, mem_write, mem_writedata,
    output mem_readdata, mem_waitrequest
  );
endinterface

// File: rtl/niosii_usb_cpu_cpu_debug_mem_sequencer.sv
// Turns debug-slave command pulses into single OCI memory reads/writes with
// address auto-increment, wait timeout and sticky error reporting.
module niosii_usb_cpu_cpu_debug_mem_sequencer #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                take_action_ocimem_a,
  input  logic                take_no_action_ocimem_a,
  input  logic                take_action_ocimem_b,
  input  logic [37:0]         jdo,
  niosii_usb_cpu_cpu_debug_mem_sequencer_if.master mem,
  output logic [DATA_W-1:0]   MonDReg,
  output logic                monitor_ready,
  output logic                monitor_error,
  output logic                busy
);

  typedef enum logic [1:0] {IDLE, RD, WR} state_t;

  state_t      state;
  logic [7:0]  wait_cnt;
  logic        any_pulse;
  logic        unused_jdo;

  assign any_pulse  = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
  assign busy       = (state != IDLE);
  assign unused_jdo = &{1'b0, jdo};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= IDLE;
      wait_cnt          <= '0;
      mem.mem_address   <= '0;
      mem.mem_writedata <= '0;
      mem.mem_read      <= 1'b0;
      mem.mem_write     <= 1'b0;
      MonDReg           <= '0;
      monitor_ready     <= 1'b1;
      monitor_error     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // Only the highest-priority pulse is honoured; the rest are dropped silently.
          if (take_action_ocimem_a) begin
            mem.mem_address <= jdo[25+ADDR_W:26];
            monitor_error   <= 1'b0;
            if (jdo[17]) begin
              state         <= RD;
              mem.mem_read  <= 1'b1;
              monitor_ready <= 1'b0;
              wait_cnt      <= '0;
            end
          end else if (take_action_ocimem_b) begin
            mem.mem_writedata <= jdo[34:3];
            state             <= WR;
            mem.mem_write     <= 1'b1;
            monitor_ready     <= 1'b0;
            wait_cnt          <= '0;
          end else if (take_no_action_ocimem_a) begin
            state         <= RD;
            mem.mem_read  <= 1'b1;
            monitor_ready <= 1'b0;
            wait_cnt      <= '0;
          end
        end
        RD, WR: begin
          if (any_pulse) begin
            monitor_error <= 1'b1;
          end
          if (!mem.mem_waitrequest) begin
            if (state == RD) begin
              MonDReg <= mem.mem_readdata;
            end
            mem.mem_address <= mem.mem_address + 1'b1;
            mem.mem_read    <= 1'b0;
            mem.mem_write   <= 1'b0;
            monitor_ready   <= 1'b1;
            state           <= IDLE;
          end else if (wait_cnt == 8'(TIMEOUT)) begin
            // Abort leaves address and read data untouched so the host can retry.
            mem.mem_read  <= 1'b0;
            mem.mem_write <= 1'b0;
            monitor_error <= 1'b1;
            monitor_ready <= 1'b1;
            state         <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: begin
          mem.mem_read  <= 1'b0;
          mem.mem_write <= 1'b0;
          monitor_ready <= 1'b1;
          state         <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_niosii_usb_cpu_cpu_debug_mem_sequencer.sv
// Randomized bench for the debug memory sequencer against a transaction-level model.
module tb_niosii_usb_cpu_cpu_debug_mem_sequencer;
  localparam int ADDR_W  = 8;
  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ta_a = 1'b0, tna_a = 1'b0, ta_b = 1'b0;
  logic [37:0] jdo = '0;
  logic [31:0] MonDReg;
  logic        monitor_ready, monitor_error, busy;

  niosii_usb_cpu_cpu_debug_mem_sequencer_if #(.ADDR_W(ADDR_W), .DATA_W(32)) bus ();

  niosii_usb_cpu_cpu_debug_mem_sequencer #(.ADDR_W(ADDR_W), .DATA_W(32), .TIMEOUT(TIMEOUT)) u_dut (
    .clk                     (clk),
    .reset                   (reset),
    .take_action_ocimem_a    (ta_a),
    .take_no_action_ocimem_a (tna_a),
    .take_action_ocimem_b    (ta_b),
    .jdo                     (jdo),
    .mem                     (bus),
    .MonDReg                 (MonDReg),
    .monitor_ready           (monitor_ready),
    .monitor_error           (monitor_error),
    .busy                    (busy)
  );

  always #5 clk = ~clk;

  // Slave memory: unwritten words read back a fixed address pattern.
  function automatic logic [31:0] init_pat(logic [7:0] a);
    if (a == 8'h10) return 32'hDEADBEEF;
    return {a, ~a, a ^ 8'h5A, 8'hC3};
  endfunction

  logic [31:0] slave_mem [256];
  bit          written [256];
  int          wait_n = 0;
  int          scnt;

  function automatic logic [31:0] slave_word(logic [7:0] a);
    return written[a] ? slave_mem[a] : init_pat(a);
  endfunction

  assign bus.mem_waitrequest = (bus.mem_read | bus.mem_write) && (scnt < wait_n);
  assign bus.mem_readdata    = slave_word(bus.mem_address);

  always @(posedge clk or posedge reset) begin
    if (reset) scnt <= 0;
    else if (bus.mem_read | bus.mem_write) scnt <= scnt + 1;
    else scnt <= 0;
  end

  always @(posedge clk) begin
    if (bus.mem_write && !bus.mem_waitrequest) begin
      slave_mem[bus.mem_address] <= bus.mem_writedata;
      written[bus.mem_address]   <= 1'b1;
    end
  end

  // Reference model state
  int          n_vec = 0, n_err = 0;
  int          m_addr;
  logic [31:0] m_mon;
  bit          m_ready, m_err;
  logic [31:0] ref_mem [256];

  task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_pulses();
    ta_a = 1'b0; tna_a = 1'b0; ta_b = 1'b0;
  endtask

  function automatic logic [37:0] rand_jdo();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[37:0];
  endfunction

  function automatic logic [37:0] mk_jdo(logic [7:0] a, bit rd);
    logic [37:0] j;
    j = rand_jdo();
    j[33:26] = a;
    j[17] = rd;
    return j;
  endfunction

  function automatic logic [37:0] mk_wjdo(logic [31:0] d);
    logic [37:0] j;
    j = rand_jdo();
    j[34:3] = d;
    return j;
  endfunction

  task automatic pulse_rand();
    case ($urandom_range(2))
      0: ta_a = 1'b1;
      1: tna_a = 1'b1;
      default: ta_b = 1'b1;
    endcase
    jdo = rand_jdo();
  endtask

  task automatic check_state(string tag);
    check_eq({tag, "_addr"},  32'(bus.mem_address), 32'(m_addr));
    check_eq({tag, "_mon"},   MonDReg, m_mon);
    check_eq({tag, "_ready"}, 32'(monitor_ready), 32'(m_ready));
    check_eq({tag, "_err"},   32'(monitor_error), 32'(m_err));
    check_eq({tag, "_busy"},  32'(busy), 32'd0);
    check_eq({tag, "_strb"},  32'({bus.mem_read, bus.mem_write}), 32'd0);
  endtask

  // One command: kind 0 = no transaction, 1 = read, 2 = write.
  task automatic do_cmd(bit pa, bit pna, bit pb, logic [37:0] j, int waits, int inject);
    int          kind, len, exp_len, a0;
    bit          to;
    logic [31:0] d;
    d = j[34:3];
    if (pa) begin
      m_addr = int'(j[33:26]);
      m_err  = 1'b0;
      kind   = j[17] ? 1 : 0;
    end else if (pb) kind = 2;
    else if (pna) kind = 1;
    else kind = 0;

    wait_n = waits;
    ta_a = pa; tna_a = pna; ta_b = pb; jdo = j;
    tick();
    clear_pulses();
    jdo = rand_jdo();

    if (kind == 0) begin
      check_state("idle_cmd");
      return;
    end

    to      = (waits > TIMEOUT);
    exp_len = (to ? TIMEOUT : waits) + 1;
    a0      = m_addr;
    len     = 0;
    while ((bus.mem_read || bus.mem_write) && len < 300) begin
      if (len == 0) begin
        check_eq("strb_addr", 32'(bus.mem_address), 32'(a0));
        check_eq("strb_kind", 32'({bus.mem_read, bus.mem_write}), (kind == 1) ? 32'd2 : 32'd1);
        check_eq("strb_ready", 32'(monitor_ready), 32'd0);
        check_eq("strb_busy", 32'(busy), 32'd1);
        if (kind == 2) check_eq("strb_wdata", bus.mem_writedata, d);
      end
      if (len == inject) pulse_rand();
      tick();
      clear_pulses();
      len++;
    end

    if (inject >= 0 && inject < exp_len) m_err = 1'b1;
    if (to) begin
      m_err = 1'b1;
    end else begin
      if (kind == 1) m_mon = ref_mem[a0];
      else ref_mem[a0] = d;
      m_addr = (a0 + 1) % (1 << ADDR_W);
    end
    m_ready = 1'b1;

    check_eq("strb_len", 32'(len), 32'(exp_len));
    if (kind == 2) check_eq("mem_word", slave_word(8'(a0)), ref_mem[a0]);
    check_state("done");
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int pick, w, inj;
    bit pa, pb, pna;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_pat(8'(i));
    m_addr = 0; m_mon = '0; m_ready = 1'b1; m_err = 1'b0;

    tick(); tick();
    check_state("reset");
    reset = 1'b0;
    tick();

    // Zero-wait read at 0x10
    do_cmd(1'b1, 1'b0, 1'b0, mk_jdo(8'h10, 1'b1), 0, -1);

    // Three waited writes across the address wrap
    do_cmd(1'b1, 1'b0, 1'b0, mk_jdo(8'hFE, 1'b0), 0, -1);
    for (int i = 1; i <= 3; i++) do_cmd(1'b0, 1'b0, 1'b1, mk_wjdo(32'(i)), 2, -1);

    // Timeout on both exact boundaries, then error cleared by an address load
    do_cmd(1'b1, 1'b0, 1'b0, mk_jdo(8'h20, 1'b1), TIMEOUT, -1);
    do_cmd(1'b1, 1'b0, 1'b0, mk_jdo(8'h20, 1'b1), TIMEOUT + 1, -1);
    do_cmd(1'b1, 1'b0, 1'b0, mk_jdo(8'h20, 1'b0), 0, -1);

    // Overrun pulse during a waited read
    do_cmd(1'b0, 1'b1, 1'b0, rand_jdo(), 4, 2);

    // Simultaneous address load (no read) and write
    do_cmd(1'b1, 1'b0, 1'b1, mk_jdo(8'h05, 1'b0), 0, -1);

    // Reset during the second wait cycle of a write
    do_cmd(1'b1, 1'b0, 1'b0, mk_jdo(8'h40, 1'b0), 0, -1);
    wait_n = 5;
    ta_b = 1'b1; jdo = mk_wjdo(32'hCAFEF00D);
    tick();
    clear_pulses();
    tick();
    #2;
    reset = 1'b1;
    #1;
    m_addr = 0; m_mon = '0; m_ready = 1'b1; m_err = 1'b0;
    check_state("mid_reset");
    check_eq("mid_reset_wdata", bus.mem_writedata, 32'd0);
    tick();
    reset = 1'b0;
    tick();
    check_eq("reset_no_write", slave_word(8'h40), ref_mem[8'h40]);
    do_cmd(1'b0, 1'b1, 1'b0, rand_jdo(), 1, -1);

    // Randomized command stream
    for (int i = 0; i < 150; i++) begin
      pa  = ($urandom_range(2) == 0);
      pb  = ($urandom_range(2) == 0);
      pna = ($urandom_range(2) == 0);
      if (!pa && !pb && !pna) pna = 1'b1;
      pick = $urandom_range(9);
      if (pick <= 5) w = $urandom_range(3);
      else if (pick == 6) w = TIMEOUT;
      else if (pick == 7) w = TIMEOUT + 1;
      else if (pick == 8) w = $urandom_range(40, 20);
      else w = $urandom_range(14, 4);
      inj = ($urandom_range(3) == 0) ? $urandom_range((w > TIMEOUT) ? TIMEOUT : w) : -1;
      do_cmd(pa, pna, pb, rand_jdo(), w, inj);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/niosii_usb_cpu_cpu_debug_mem_sequencer.md
# niosii_USB_cpu_cpu_debug_mem_sequencer

System-clock-side sequencer for debug-slave memory accesses. It decodes the single-cycle `take_action_*` command pulses and the `jdo` shift-register snapshot from the debug slave sysclk stage. It then drives an Avalon-style read/write master to OCI memory, with address auto-increment and a wait timeout. It returns read data and status (`MonDReg`, `monitor_ready`, `monitor_error`) to the debug slave for JTAG readback.

## Interface
Parameters:
- `ADDR_W`, 8: OCI memory word-address width (≤ 11).
- `DATA_W`, 32: data width. Fixed at 32 in this design.
- `TIMEOUT`, 15: maximum number of `mem_waitrequest` cycles before abort (1–255).

Ports:
- `clk`  in  1  system clock; one clock domain.
- `reset`  in  1  asynchronous, active-high reset.
- `take_action_ocimem_a`  in  1  pulse: load address `jdo[25+ADDR_W:26]`. If `jdo[17]`=1, also issue a read.
- `take_no_action_ocimem_a`  in  1  pulse: read at the current address.
- `take_action_ocimem_b`  in  1  pulse: write `jdo[34:3]` at the current address.
- `jdo`  in  38  command/data snapshot; valid in the pulse cycle only.
- `mem_address`  out  ADDR_W  word address.
- `mem_read`  out  1  read strobe.
- `mem_write`  out  1  write strobe.
- `mem_writedata`  out  32  write data.
- `mem_readdata`  in  32  read data; valid in the cycle `mem_waitrequest`=0 while `mem_read`=1.
- `mem_waitrequest`  in  1  slave stall.
- `MonDReg`  out  32  last read data.
- `monitor_ready`  out  1  idle; the result in `MonDReg` is valid.
- `monitor_error`  out  1  sticky error: timeout or command overrun.
- `busy`  out  1  transaction in flight.

## Operation
- States:
  - IDLE: accepts commands.
  - RD: `mem_read`=1.
  - WR: `mem_write`=1.
- IDLE transitions:
  - `take_action_ocimem_a`: load the address register. Clear `monitor_error`. If `jdo[17]`, go to RD; otherwise stay in IDLE.
  - `take_no_action_ocimem_a`: go to RD.
  - `take_action_ocimem_b`: latch `jdo[34:3]` into `mem_writedata`, then go to WR.
- Simultaneous pulses in IDLE: priority is `take_action_ocimem_a` > `take_action_ocimem_b` > `take_no_action_ocimem_a`. Lower-priority pulses are discarded and no error is raised.
- Any pulse while in RD or WR is discarded and sets `monitor_error`. The current transaction continues unaffected.
- Leaving IDLE for RD or WR clears `monitor_ready`.
- RD/WR completion occurs in the first cycle with `mem_waitrequest`=0:
  - For RD, `MonDReg` <= `mem_readdata`.
  - The address increments by 1, modulo 2^ADDR_W; (2^ADDR_W−1) wraps to 0.
  - `monitor_ready` is set, and the state returns to IDLE.
- Wait counter (8-bit):
  - Cleared on entry to RD or WR.
  - Increments each cycle that `mem_waitrequest`=1.
  - When it equals `TIMEOUT` with `mem_waitrequest` still 1, the transaction aborts: strobe dropped, `monitor_error`=1, `monitor_ready`=1, address not incremented, `MonDReg` unchanged, state returns to IDLE.
- `mem_address`, `mem_writedata`, and the strobes come directly from registers.
- `busy` = (state != IDLE).

## Timing
- Reset values:
  - state = IDLE.
  - `mem_address`, `mem_writedata`, `MonDReg` = 0.
  - `mem_read` = `mem_write` = 0.
  - `monitor_ready` = 1.
  - `monitor_error` = 0.
  - `busy` = 0.
- Command latency: pulse in cycle N puts the strobe high in N+1.
- Zero-wait slave: strobe high for exactly 1 cycle (N+1). `MonDReg`, address increment, and `monitor_ready` become visible in N+2.
- Each wait cycle extends the strobe by one cycle.
- Timeout: with `mem_waitrequest` held high, the strobe is high for `TIMEOUT`+1 cycles. The strobe is low and `monitor_error`=1 in the following cycle.
- Back-to-back: a new command is accepted in the cycle the state is IDLE again, i.e. N+2 at the earliest.
- `reset` asserted mid-transaction clears the strobes asynchronously. There is no completion, and `MonDReg` is cleared.

## Test plan
- Reset, then `take_action_ocimem_a` with address 0x10 and `jdo[17]`=1, slave `mem_readdata`=0xDEADBEEF with zero wait → `mem_read` high 1 cycle at address 0x10. Then `MonDReg`=0xDEADBEEF, `mem_address`=0x11, `monitor_ready`=1.
- Three `take_action_ocimem_b` writes (0x1, 0x2, 0x3) starting at address 0xFE, 2 wait cycles each → writes land at 0xFE, 0xFF, 0x00. Each strobe lasts 3 cycles. The address wraps to 0x00, then 0x01.
- Read with `mem_waitrequest` stuck high and `TIMEOUT`=15 → strobe high for 16 cycles, then dropped. `monitor_error`=1, address unchanged, `MonDReg` unchanged. A following `take_action_ocimem_a` clears `monitor_error`.
- `take_no_action_ocimem_a` during a waited read → ignored and `monitor_error`=1. The original read still completes with correct data.
- `take_action_ocimem_a` (`jdo[17]`=0, address 0x05) and `take_action_ocimem_b` in the same cycle → address becomes 0x05, no write, no error, `monitor_ready` stays 1.
- `reset` pulsed during the 2nd wait cycle of a write → `mem_write` drops immediately. All outputs return to reset values, and a following read works normally.
